// File: rtl/incr_sweep.sv
// Frequency-sweep generator: steps a counter increment from start to stop, holding each value for a dwell period.
// Optional INCR_SWEEP_LOOP_EN adds loop_i for a repeating sawtooth sweep.
module incr_sweep #(
    parameter int W       = 32,
    parameter int DWELL_W = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start_i,
    input  logic               abort_i,
`ifdef INCR_SWEEP_LOOP_EN
    input  logic               loop_i,
`endif
    input  logic [W-1:0]       f_start_i,
    input  logic [W-1:0]       f_stop_i,
    input  logic [W-1:0]       f_step_i,
    input  logic [DWELL_W-1:0] dwell_i,
    output logic [W-1:0]       incr_o,
    output logic               busy_o,
    output logic               step_o,
    output logic               done_o,
    output logic [1:0]         dbg_state_o
);

    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, LAST = 2'd2} state_t;

    state_t             state;
    logic [W-1:0]       stop_r;
    logic [W-1:0]       step_r;
    logic               up_r;
    logic [DWELL_W-1:0] dwell_m1_r;
    logic [DWELL_W-1:0] cnt;
`ifdef INCR_SWEEP_LOOP_EN
    logic [W-1:0]       start_r;
    logic               loop_r;
`endif

    logic [DWELL_W-1:0] dwell_in_m1;
    logic [W:0]         sum;
    logic [W:0]         diff;
    logic [W-1:0]       nxt;

    // A dwell of 0 behaves as 1; cnt counts remaining hold cycles minus one.
    assign dwell_in_m1 = (dwell_i == '0) ? '0 : dwell_i - DWELL_W'(1);
    assign sum         = {1'b0, incr_o} + {1'b0, step_r};
    assign diff        = {1'b0, incr_o} - {1'b0, step_r};
    assign dbg_state_o = state;

    // Any overshoot, overflow, borrow or zero step lands exactly on stop.
    always_comb begin
        nxt = stop_r;
        if (step_r != '0) begin
            if (up_r) begin
                if (sum < {1'b0, stop_r}) nxt = sum[W-1:0];
            end else begin
                if (!diff[W] && (diff[W-1:0] > stop_r)) nxt = diff[W-1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            incr_o     <= '0;
            busy_o     <= 1'b0;
            step_o     <= 1'b0;
            done_o     <= 1'b0;
            stop_r     <= '0;
            step_r     <= '0;
            up_r       <= 1'b0;
            dwell_m1_r <= '0;
            cnt        <= '0;
`ifdef INCR_SWEEP_LOOP_EN
            start_r    <= '0;
            loop_r     <= 1'b0;
`endif
        end else begin
            step_o <= 1'b0;
            done_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_i && !abort_i) begin
                        incr_o     <= f_start_i;
                        stop_r     <= f_stop_i;
                        step_r     <= f_step_i;
                        up_r       <= (f_stop_i > f_start_i);
                        dwell_m1_r <= dwell_in_m1;
                        cnt        <= dwell_in_m1;
                        busy_o     <= 1'b1;
                        step_o     <= 1'b1;
                        state      <= (f_start_i == f_stop_i) ? LAST : RUN;
`ifdef INCR_SWEEP_LOOP_EN
                        start_r    <= f_start_i;
                        loop_r     <= loop_i;
`endif
                    end
                end
                RUN: begin
                    if (abort_i) begin
                        busy_o <= 1'b0;
                        state  <= IDLE;
                    end else if (cnt != '0) begin
                        cnt <= cnt - DWELL_W'(1);
                    end else begin
                        incr_o <= nxt;
                        step_o <= 1'b1;
                        cnt    <= dwell_m1_r;
                        state  <= (nxt == stop_r) ? LAST : RUN;
                    end
                end
                LAST: begin
                    if (abort_i) begin
                        busy_o <= 1'b0;
                        state  <= IDLE;
                    end else if (cnt != '0) begin
                        cnt <= cnt - DWELL_W'(1);
                    end else begin
                        done_o <= 1'b1;
`ifdef INCR_SWEEP_LOOP_EN
                        if (loop_r) begin
                            incr_o <= start_r;
                            step_o <= 1'b1;
                            cnt    <= dwell_m1_r;
                            state  <= (start_r == stop_r) ? LAST : RUN;
                        end else begin
                            busy_o <= 1'b0;
                            state  <= IDLE;
                        end
`else
                        busy_o <= 1'b0;
                        state  <= IDLE;
`endif
                    end
                end
                default: begin
                    busy_o <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_incr_sweep.sv
// Directed table-driven bench for incr_sweep plus hand sequences for abort, ignored start and reset.
module tb_incr_sweep;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start_i = 1'b0;
    logic        abort_i = 1'b0;
    logic        loop_i = 1'b0;
    logic [31:0] f_start_i = '0;
    logic [31:0] f_stop_i = '0;
    logic [31:0] f_step_i = '0;
    logic [15:0] dwell_i = '0;
    logic [31:0] incr_o;
    logic        busy_o;
    logic        step_o;
    logic        done_o;
    logic [1:0]  dbg_state_o;

    int checks = 0;
    int errors = 0;

    incr_sweep #(.W(32), .DWELL_W(16)) dut (
        .clk(clk),
        .reset(reset),
        .start_i(start_i),
        .abort_i(abort_i),
`ifdef INCR_SWEEP_LOOP_EN
        .loop_i(loop_i),
`endif
        .f_start_i(f_start_i),
        .f_stop_i(f_stop_i),
        .f_step_i(f_step_i),
        .dwell_i(dwell_i),
        .incr_o(incr_o),
        .busy_o(busy_o),
        .step_o(step_o),
        .done_o(done_o),
        .dbg_state_o(dbg_state_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0]      start;
        logic [31:0]      stop;
        logic [31:0]      step;
        logic [15:0]      dwell;
        int               n;
        logic [5:0][31:0] vals;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_outs(input string tag, input logic [31:0] e_incr, input logic e_busy,
                            input logic e_step, input logic e_done);
        chk({tag, ".incr"}, incr_o, e_incr);
        chk({tag, ".busy"}, {31'd0, busy_o}, {31'd0, e_busy});
        chk({tag, ".step"}, {31'd0, step_o}, {31'd0, e_step});
        chk({tag, ".done"}, {31'd0, done_o}, {31'd0, e_done});
    endtask

    task automatic set_cfg(input logic [31:0] s, input logic [31:0] p, input logic [31:0] st,
                           input logic [15:0] d);
        f_start_i = s;
        f_stop_i  = p;
        f_step_i  = st;
        dwell_i   = d;
    endtask

    // Pulses start, scrambles the config inputs, then checks every cycle through done and one hold cycle.
    task automatic run_vec(input vec_t v);
        int d;
        int total;
        d = (v.dwell == 16'd0) ? 1 : int'(v.dwell);
        total = v.n * d;
        set_cfg(v.start, v.stop, v.step, v.dwell);
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        set_cfg(32'hdead_beef, 32'h0000_1234, 32'd7, 16'd9);
        for (int c = 0; c <= total + 1; c++) begin
            if (c < total) chk_outs("sweep", v.vals[c / d], 1'b1, (c % d) == 0, 1'b0);
            else if (c == total) chk_outs("done", v.stop, 1'b0, 1'b0, 1'b1);
            else chk_outs("hold", v.stop, 1'b0, 1'b0, 1'b0);
            if (c <= total) @(negedge clk);
        end
    endtask

    initial begin
        vecs[0] = '{32'd2, 32'd10, 32'd2, 16'd5, 5,
                    {32'd0, 32'd10, 32'd8, 32'd6, 32'd4, 32'd2}};
        vecs[1] = '{32'd10, 32'd1, 32'd4, 16'd1, 4,
                    {32'd0, 32'd0, 32'd1, 32'd2, 32'd6, 32'd10}};
        vecs[2] = '{32'd4, 32'd4, 32'd3, 16'd0, 1,
                    {32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd4}};
        vecs[3] = '{32'hFFFF_FFF0, 32'hFFFF_FFFF, 32'h20, 16'd1, 2,
                    {32'd0, 32'd0, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFF0}};
        vecs[4] = '{32'd3, 32'd9, 32'd0, 16'd2, 2,
                    {32'd0, 32'd0, 32'd0, 32'd0, 32'd9, 32'd3}};
        vecs[5] = '{32'd100, 32'd0, 32'd30, 16'd3, 5,
                    {32'd0, 32'd0, 32'd10, 32'd40, 32'd70, 32'd100}};
        vecs[6] = '{32'hFFFF_FFFF, 32'd0, 32'hFFFF_FFFF, 16'd2, 2,
                    {32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'hFFFF_FFFF}};
        vecs[7] = '{32'd5, 32'd20, 32'd5, 16'd1, 4,
                    {32'd0, 32'd0, 32'd20, 32'd15, 32'd10, 32'd5}};

        repeat (3) @(negedge clk);
        chk_outs("reset", 32'd0, 1'b0, 1'b0, 1'b0);
        chk("reset.state", {30'd0, dbg_state_o}, 32'd0);
        reset = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 8; i++) run_vec(vecs[i]);

        // Up sweep with an ignored mid-sweep start, then abort while holding 6.
        set_cfg(32'd2, 32'd10, 32'd2, 16'd5);
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        for (int c = 0; c <= 12; c++) begin
            chk_outs("pre_abort", 32'd2 + 32'd2 * 32'(c / 5), 1'b1, (c % 5) == 0, 1'b0);
            if (c == 3) begin
                set_cfg(32'd50, 32'd60, 32'd1, 16'd1);
                start_i = 1'b1;
            end else begin
                start_i = 1'b0;
            end
            if (c == 12) abort_i = 1'b1;
            @(negedge clk);
        end
        abort_i = 1'b0;
        chk_outs("abort", 32'd6, 1'b0, 1'b0, 1'b0);
        chk("abort.state", {30'd0, dbg_state_o}, 32'd0);
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            chk_outs("after_abort", 32'd6, 1'b0, 1'b0, 1'b0);
        end

        // Start and abort together in idle: abort wins.
        set_cfg(32'd77, 32'd99, 32'd1, 16'd1);
        start_i = 1'b1;
        abort_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        abort_i = 1'b0;
        chk_outs("start_abort", 32'd6, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        chk_outs("start_abort2", 32'd6, 1'b0, 1'b0, 1'b0);

        // Reset mid-sweep, then a clean sweep.
        set_cfg(32'd2, 32'd10, 32'd2, 16'd5);
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        repeat (7) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk_outs("mid_reset", 32'd0, 1'b0, 1'b0, 1'b0);
        chk("mid_reset.state", {30'd0, dbg_state_o}, 32'd0);
        run_vec(vecs[1]);

`ifdef INCR_SWEEP_LOOP_EN
        // Looping sawtooth 0,2,4 with dwell 2; done pulses with each reload.
        set_cfg(32'd0, 32'd4, 32'd2, 16'd2);
        loop_i = 1'b1;
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        loop_i = 1'b0;
        for (int c = 0; c < 18; c++) begin
            chk_outs("loop", 32'd2 * 32'((c % 6) / 2), 1'b1, (c % 2) == 0, (c > 0) && ((c % 6) == 0));
            if (c == 17) abort_i = 1'b1;
            @(negedge clk);
        end
        abort_i = 1'b0;
        chk_outs("loop_abort", 32'd4, 1'b0, 1'b0, 1'b0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/incr_sweep.md
# incr_sweep

Programmable frequency-sweep generator that sits directly upstream of `counter` and drives its `incr_i`. On a start request it steps its output increment from a start value to a stop value in fixed steps. Each value is held for a programmable number of clock cycles. The downstream counter therefore produces a linear chirp (phase ramp with ramping slope). Once the sweep completes, the block holds the final increment so the counter keeps running at the stop frequency.

## Interface
- `W`, 32, width of increment values; must match `counter` increment width.
- `DWELL_W`, 16, width of dwell-count input.

- `clk`  in  1  system clock (100 MHz nominal); all logic on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `start_i`  in  1  start request; sampled only in IDLE.
- `abort_i`  in  1  terminate sweep; freeze output at current value.
- `f_start_i`  in  W  first increment value (unsigned).
- `f_stop_i`  in  W  final increment value (unsigned).
- `f_step_i`  in  W  step magnitude (unsigned); direction derived from start/stop.
- `dwell_i`  in  DWELL_W  cycles each value is held; 0 treated as 1.
- `incr_o`  out  W  registered increment, connects to `counter.incr_i`.
- `busy_o`  out  1  high while sweeping.
- `step_o`  out  1  one-cycle pulse on every `incr_o` update during a sweep, including the first load.
- `done_o`  out  1  one-cycle pulse when the sweep completes normally.
- `loop_i`  in  1  present only with `INCR_SWEEP_LOOP_EN` (see Configuration).

## Operation
- States:
  - IDLE: waits for `start_i`.
  - RUN: holds the current value for the dwell period, then updates.
  - LAST: holds `f_stop` for the final dwell period.
- Transitions:
  - IDLE → RUN on `start_i`. Latches `f_start_i`, `f_stop_i`, `f_step_i` and `dwell_i` into internal registers. Later input changes have no effect until the next start.
  - If latched start == stop, IDLE → LAST directly.
- Direction: up if stop > start, down if stop < start.
- Step arithmetic is done in W+1 bits, with no wrap-around.
  - Next value = cur ± step. If that overshoots stop or overflows the range, next value = stop.
  - `f_step` = 0 with start ≠ stop: next value = stop.
- RUN → LAST when the updated value equals stop.
- LAST → IDLE after the dwell period expires. Pulses `done_o`; `incr_o` holds stop.
- `abort_i` in RUN or LAST → IDLE on the next edge. `incr_o` keeps its present value and no `done_o` pulse is issued.
- `start_i` is ignored while `busy_o` = 1.
- If `start_i` and `abort_i` are asserted together in IDLE, abort wins and no sweep starts.
- `reset` has priority over all inputs and may be asserted at any point mid-sweep. On the next edge all state returns to reset values.

## Timing
- Reset values: `incr_o` = 0, `busy_o` = 0, `step_o` = 0, `done_o` = 0, state = IDLE, dwell counter = 0.
- `start_i` high at edge N:
  - `incr_o` = f_start, `busy_o` = 1 and `step_o` = 1, all visible after edge N.
- Each value is held for exactly max(dwell, 1) cycles. The next value and a `step_o` pulse appear on the following edge.
- Total sweep length is (number of distinct values) × max(dwell, 1) cycles, measured from the first `busy_o` high.
- Completion: `done_o` = 1 and `busy_o` = 0 in the same cycle, on the edge that ends the final dwell. `done_o` is high for one cycle only.
- Abort: `busy_o` = 0 one cycle after `abort_i` is sampled. `step_o` and `done_o` stay 0.
- `incr_o` is registered, with no combinational path from any input.

## Configuration
- `INCR_SWEEP_LOOP_EN` defined:
  - Adds the `loop_i` port, latched at start.
  - If latched high, LAST does not go to IDLE. It reloads f_start with a `step_o` pulse and continues the sweep, producing a repeating sawtooth.
  - `done_o` still pulses once per completed pass. `busy_o` stays 1.
  - A looping sweep ends only by `abort_i` or `reset`.
- `INCR_SWEEP_LOOP_EN` undefined: no `loop_i` port; single-shot sweep only, exactly as described above.

## Test plan
- Up sweep: start=2, stop=10, step=2, dwell=5, pulse start → `incr_o` = 2,4,6,8,10, each held 5 cycles; 5 `step_o` pulses; `done_o` 25 cycles after the first `busy_o` high; `incr_o` remains 10.
- Down sweep with clamp: start=10, stop=1, step=4, dwell=1 → `incr_o` = 10,6,2,1; `done_o` after 4 cycles.
- Edge values:
  - start=stop=4, dwell=0 → one cycle at 4, then `done_o`.
  - start=0xFFFFFFF0, stop=0xFFFFFFFF, step=0x20 → 0xFFFFFFF0 then 0xFFFFFFFF, with no wrap.
- Abort and ignored start:
  - Abort during value 6 of the up sweep → `incr_o` frozen at 6, `busy_o` low next cycle, no `done_o`.
  - `start_i` pulsed mid-sweep → no effect.
- Reset mid-sweep → next edge: `incr_o` = 0 and all flags 0. A subsequent start runs a clean sweep.
- With `INCR_SWEEP_LOOP_EN`, loop_i=1, start=0, stop=4, step=2, dwell=2 → 0,2,4,0,2,4…; `done_o` every 6 cycles; abort stops the sequence.
